// File: rtl/mtr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mtr_pkg
//  Purpose  : Shared types and constants for the motor ramp controller.
//             Speed width and symmetric speed limits, the ramp state
//             encoding and the capture-time saturation helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mtr_pkg;

    localparam int SPD_W = 11;

    typedef logic signed [SPD_W-1:0] spd_t;

    localparam spd_t SPD_MAX = 11'sd1023;
    localparam spd_t SPD_MIN = -11'sd1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWELL = 2'd2,
        STOP  = 2'd3
    } ramp_state_t;

    // Clamp to the symmetric range; with 11 bits only -1024 can fall outside,
    // which keeps the drive's offset duty strictly inside 1..2047.
    function automatic spd_t satSpd(input spd_t v);
        if (v < SPD_MIN) return SPD_MIN;
        if (v > SPD_MAX) return SPD_MAX;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_chan.sv
`default_nettype none
// ============================================================================
//  Module   : ramp_chan
//  Purpose  : One speed channel. Holds the live speed and latched target,
//             computes the next slew-limited speed and flags when a pending
//             direction reversal has brought the channel to zero.
//  Ports    : clk, rst        clock, async active-high reset
//             i_clear         force live speed and target to 0 (emergency stop)
//             i_capture       latch i_tgt (saturated) as the new target
//             i_tgt           signed target input
//             i_stepEn        apply one ramp step this cycle
//             i_zeroEff       ramp toward 0 instead of the target
//             o_curSpd        live speed
//             o_tgtSpd        latched target
//             o_hitZero       reversal pending and the next step lands on 0
//  Revision : 1.0 - initial release
// ============================================================================
module ramp_chan
    import mtr_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_capture,
    input  logic signed [SPD_W-1:0] i_tgt,
    input  logic                    i_stepEn,
    input  logic                    i_zeroEff,
    output logic signed [SPD_W-1:0] o_curSpd,
    output logic signed [SPD_W-1:0] o_tgtSpd,
    output logic                    o_hitZero
);

    localparam logic signed [SPD_W:0] c_STEP_EXT = (SPD_W+1)'(STEP);
    localparam spd_t                  c_STEP     = spd_t'(STEP);

    spd_t                  r_cur;
    spd_t                  r_tgt;
    spd_t                  w_eff;
    spd_t                  w_stepMag;
    spd_t                  w_next;
    logic signed [SPD_W:0] w_diff;
    logic signed [SPD_W:0] w_mag;
    logic                  w_revPend;

    always_comb begin
        // Opposite, non-zero signs: the channel must pass through zero first.
        w_revPend = (r_cur != '0) && (r_tgt != '0) &&
                    (r_cur[SPD_W-1] != r_tgt[SPD_W-1]);
        w_eff     = (i_zeroEff || w_revPend) ? '0 : r_tgt;
        // One extra bit so the full -2046..+2046 difference is representable.
        w_diff    = {w_eff[SPD_W-1], w_eff} - {r_cur[SPD_W-1], r_cur};
        w_mag     = w_diff[SPD_W] ? -w_diff : w_diff;
        w_stepMag = (w_mag > c_STEP_EXT) ? c_STEP : spd_t'(w_mag);
        w_next    = w_diff[SPD_W] ? (r_cur - w_stepMag) : (r_cur + w_stepMag);
        o_hitZero = w_revPend && (w_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur <= '0;
            r_tgt <= '0;
        end else if (i_clear) begin
            r_cur <= '0;
            r_tgt <= '0;
        end else begin
            // Step reads the old target when a capture lands on the same edge.
            if (i_capture) r_tgt <= satSpd(i_tgt);
            if (i_stepEn)  r_cur <= w_next;
        end
    end

    assign o_curSpd = r_cur;
    assign o_tgtSpd = r_tgt;

endmodule
`default_nettype wire

// File: rtl/mtr_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mtr_ramp_ctrl
//  Purpose  : Slew-rate controller sequencing signed left/right speed
//             commands into the motor drive. Ramps at STEP per tick, forces
//             a zero-speed dwell before any reversal, supports orderly
//             ramp-down (en=0) and emergency stop.
//  Ports    : clk, rst            clock, async active-high reset
//             en                  run enable (0 = ramp both channels to 0)
//             estop               emergency stop, level
//             tgt_lft, tgt_rght   signed target pair
//             tgt_vld / tgt_rdy   target handshake
//             lft_spd, rght_spd   live signed speeds to the drive
//             at_tgt              both speeds at target while running
//             stopped             emergency-stop state
//  Revision : 1.0 - initial release
// ============================================================================
module mtr_ramp_ctrl
    import mtr_pkg::*;
#(
    parameter int TICK_DIV    = 1024,
    parameter int STEP        = 4,
    parameter int DWELL_TICKS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    estop,
    input  logic signed [SPD_W-1:0] tgt_lft,
    input  logic signed [SPD_W-1:0] tgt_rght,
    input  logic                    tgt_vld,
    output logic                    tgt_rdy,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    at_tgt,
    output logic                    stopped
);

    localparam int c_TICK_W  = $clog2(TICK_DIV);
    localparam int c_DWELL_W = $clog2(DWELL_TICKS + 1);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_RUN   = RUN;
    localparam logic [1:0] c_ST_DWELL = DWELL;
    localparam logic [1:0] c_ST_STOP  = STOP;

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_TICK_W-1:0]  c_TICK_ONE   = c_TICK_W'(1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LOAD = c_DWELL_W'(DWELL_TICKS);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_stNext;
    logic [c_TICK_W-1:0]  r_tickCnt;
    logic [c_DWELL_W-1:0] r_dwellCnt;
    logic                 w_active;
    logic                 w_tick;
    logic                 w_capture;
    logic                 w_stepEn;
    logic                 w_hitZeroL;
    logic                 w_hitZeroR;
    spd_t                 w_tgtL;
    spd_t                 w_tgtR;

    assign w_active  = (r_state == c_ST_RUN) || (r_state == c_ST_DWELL);
    assign w_tick    = w_active && (r_tickCnt == c_TICK_LAST);
    assign w_capture = tgt_vld && tgt_rdy && !estop;
    assign w_stepEn  = w_tick && (r_state == c_ST_RUN);

    ramp_chan #(.STEP(STEP)) u_chanLft (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (estop),
        .i_capture (w_capture),
        .i_tgt     (tgt_lft),
        .i_stepEn  (w_stepEn),
        .i_zeroEff (!en),
        .o_curSpd  (lft_spd),
        .o_tgtSpd  (w_tgtL),
        .o_hitZero (w_hitZeroL)
    );

    ramp_chan #(.STEP(STEP)) u_chanRght (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (estop),
        .i_capture (w_capture),
        .i_tgt     (tgt_rght),
        .i_stepEn  (w_stepEn),
        .i_zeroEff (!en),
        .o_curSpd  (rght_spd),
        .o_tgtSpd  (w_tgtR),
        .o_hitZero (w_hitZeroR)
    );

    always_comb begin
        w_stNext = r_state;
        if (estop) begin
            w_stNext = c_ST_STOP;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (en) w_stNext = c_ST_RUN;
                c_ST_RUN: begin
                    // One shared dwell even if both channels reverse together.
                    if (w_tick && (w_hitZeroL || w_hitZeroR))
                        w_stNext = c_ST_DWELL;
                    else if (!en && (lft_spd == '0) && (rght_spd == '0))
                        w_stNext = c_ST_IDLE;
                end
                c_ST_DWELL: begin
                    if (!en)
                        w_stNext = c_ST_RUN;
                    else if (w_tick && (r_dwellCnt == c_DWELL_ONE))
                        w_stNext = c_ST_RUN;
                end
                c_ST_STOP:  if (!en) w_stNext = c_ST_IDLE;
                default:    w_stNext = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_tickCnt  <= '0;
            r_dwellCnt <= '0;
        end else begin
            r_state <= w_stNext;
            // Counter only runs while staying in RUN/DWELL; zero everywhere else.
            if (w_active && ((w_stNext == c_ST_RUN) || (w_stNext == c_ST_DWELL)))
                r_tickCnt <= w_tick ? '0 : (r_tickCnt + c_TICK_ONE);
            else
                r_tickCnt <= '0;
            if ((r_state == c_ST_RUN) && (w_stNext == c_ST_DWELL))
                r_dwellCnt <= c_DWELL_LOAD;
            else if ((r_state == c_ST_DWELL) && w_tick)
                r_dwellCnt <= r_dwellCnt - c_DWELL_ONE;
        end
    end

    assign tgt_rdy = (r_state != c_ST_STOP);
    assign stopped = (r_state == c_ST_STOP);
    assign at_tgt  = (r_state == c_ST_RUN) && (lft_spd == w_tgtL) && (rght_spd == w_tgtR);

endmodule
`default_nettype wire
